pipelined_adder_tree: RTL and testbench

Parametrised, fully pipelined signed adder tree. It reduces `N_IN` operands per beat to one sum and can optionally accumulate sums across a burst of beats, which is how kernels wider than one beat are handled. It sits between the log-domain multiplier array and the output quantiser of the convolution datapath. It accepts one beat per clock and has no backpressure.

---
 rtl/logconv_pkg.sv | 19 +
 rtl/adder_tree_level.sv | 49 ++++
 rtl/pipelined_adder_tree.sv | 94 +++++++++
 tb/tb_pipelined_adder_tree.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/logconv_pkg.sv
// Shared constants and helpers for the log-domain convolution datapath.
// Every block derives operand and accumulator widths from here so they agree.
package logconv_pkg;

  localparam int W_DEFAULT = 13;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Result width: operand + one bit per tree level + accumulator guard bits.
  function automatic int calc_ow(input int w, input int log2n, input int acc_ext);
    return w + log2n + acc_ext;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: N operands in, N/2 pairwise sums out,
// with the valid / acc_en / last sideband delayed alongside the data.
module adder_tree_level #(
  parameter int N  = 4,
  parameter int WD = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  acc_en_i,
  input  logic                  last_i,
  input  logic [N*WD-1:0]       data_i,
  output logic                  valid_o,
  output logic                  acc_en_o,
  output logic                  last_o,
  output logic [(N/2)*WD-1:0]   data_o
);

  localparam int NO = N / 2;

  logic [NO*WD-1:0] data_d, data_q;
  logic             valid_q, acc_en_q, last_q;

  // Operands arrive already sign-extended, so a plain add wraps correctly.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < NO; k++)
      data_d[k*WD +: WD] = data_i[2*k*WD +: WD] + data_i[(2*k+1)*WD +: WD];
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_i;
  end

  // NOTE: payload registers carry no reset; they are only meaningful while
  // valid_q is set, so resetting them would just cost reset fan-out.
  always_ff @(posedge clk) begin
    data_q   <= data_d;
    acc_en_q <= acc_en_i;
    last_q   <= last_i;
  end

  assign valid_o  = valid_q;
  assign acc_en_o = acc_en_q;
  assign last_o   = last_q;
  assign data_o   = data_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree reducing N_IN operands per beat, followed by an
// optional burst accumulator. One beat per clock, no backpressure.
module pipelined_adder_tree
  import logconv_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int W       = W_DEFAULT,
  parameter int ACC_EXT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N_IN*W-1:0]      in_data,
  input  logic                   acc_en,
  input  logic                   in_last,
  output logic                   out_valid,
  output logic [calc_ow(W, clog2(N_IN), ACC_EXT)-1:0] out_data
);

  localparam int LOG2N = clog2(N_IN);
  localparam int OW    = calc_ow(W, LOG2N, ACC_EXT);
  localparam int TOT   = (2 * N_IN - 1) * OW;

  // All tree levels share one vector; level l starts at this bit offset.
  function automatic int lvl_off(input int l);
    return OW * (2 * N_IN - 2 * (N_IN >> l));
  endfunction

  logic [TOT-1:0] tree_data;
  logic [LOG2N:0] tree_vld, tree_acc, tree_lst;

  assign tree_vld[0] = in_valid;
  assign tree_acc[0] = acc_en;
  assign tree_lst[0] = in_last;

  for (genvar k = 0; k < N_IN; k++) begin : g_sext
    assign tree_data[k*OW +: OW] = {{(OW-W){in_data[k*W+W-1]}}, in_data[k*W +: W]};
  end

  for (genvar l = 0; l < LOG2N; l++) begin : g_lvl
    localparam int NI    = N_IN >> l;
    localparam int OFF_I = lvl_off(l);
    localparam int OFF_O = lvl_off(l + 1);

    adder_tree_level #(.N(NI), .WD(OW)) u_lvl (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (tree_vld[l]),
      .acc_en_i (tree_acc[l]),
      .last_i   (tree_lst[l]),
      .data_i   (tree_data[OFF_I +: NI*OW]),
      .valid_o  (tree_vld[l+1]),
      .acc_en_o (tree_acc[l+1]),
      .last_o   (tree_lst[l+1]),
      .data_o   (tree_data[OFF_O +: (NI/2)*OW])
    );
  end

  logic [OW-1:0] sum, acc_d, acc_q, out_data_q;
  logic          first_q, out_valid_q;

  assign sum   = tree_data[TOT-1 -: OW];
  assign acc_d = first_q ? sum : acc_q + sum;

  // Pass-through beats leave acc/first alone so they may sit inside a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      if (tree_vld[LOG2N]) begin
        if (!tree_acc[LOG2N]) begin
          out_valid_q <= 1'b1;
          out_data_q  <= sum;
        end else if (!tree_lst[LOG2N]) begin
          acc_q   <= acc_d;
          first_q <= 1'b0;
        end else begin
          out_valid_q <= 1'b1;
          out_data_q  <= acc_d;
          acc_q       <= '0;
          first_q     <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree (N_IN=4, W=13, OW=19) using a
// beat-level arithmetic model with a 3-slot latency line.
module tb_pipelined_adder_tree;

  localparam int N_IN = 4;
  localparam int W    = 13;
  localparam int OW   = 19;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [N_IN*W-1:0] in_data;
  logic              acc_en;
  logic              in_last;
  logic              out_valid;
  logic [OW-1:0]     out_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          v;
    logic [OW-1:0] d;
  } slot_t;

  slot_t         pipe [LAT];
  longint        m_acc;
  bit            m_first;
  logic [OW-1:0] m_last;

  pipelined_adder_tree #(.N_IN(N_IN), .W(W), .ACC_EXT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .acc_en    (acc_en),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check what the DUT shows now, then drive a new beat and
  // advance the model.
  task automatic step(input bit r, input bit v, input bit ae, input bit la,
                      input int o0, input int o1, input int o2, input int o3);
    int     ops [N_IN];
    longint s, val;
    slot_t  ns;
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, pipe[LAT-1].v});
    check("out_data", {13'b0, out_data}, {13'b0, pipe[LAT-1].d});
    ops = '{o0, o1, o2, o3};
    rst = r; in_valid = v; acc_en = ae; in_last = la;
    s = 0;
    for (int k = 0; k < N_IN; k++) begin
      in_data[k*W +: W] = ops[k][W-1:0];
      s += longint'(ops[k]);
    end
    ns.v = 1'b0;
    if (r) begin
      m_acc = 0; m_first = 1'b1; m_last = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, '0};
    end else if (v) begin
      if (!ae) begin
        ns.v = 1'b1; m_last = OW'(s);
      end else begin
        val = m_first ? s : m_acc + s;
        if (la) begin
          ns.v = 1'b1; m_last = OW'(val); m_acc = 0; m_first = 1'b1;
        end else begin
          m_acc = val; m_first = 1'b0;
        end
      end
    end
    ns.d = m_last;
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = ns;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; acc_en = 1'b0; in_last = 1'b0; in_data = '0;
    m_acc = 0; m_first = 1'b1; m_last = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, '0};
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", {13'b0, out_data}, 32'd0);

    // Single beat, then signed extremes
    step(1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 3, 3);
    idle(LAT + 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, -1, -1, -1, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4095, 4095, 4095, 4095);
    idle(LAT);

    // Back-to-back sweep of every operand combination in 0..3
    for (int i = 0; i < 256; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, i & 3, (i >> 2) & 3, (i >> 4) & 3, (i >> 6) & 3);
    idle(LAT);

    // Burst of three with a pass-through beat interleaved
    step(1'b0, 1'b1, 1'b1, 1'b0, 1, 2, 3, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4, 3, 2, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 10, 0, 0, 0);
    idle(LAT);

    // Long bursts: 16 beats fit, 17 beats wrap
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 1'b1, i == 15, 4095, 4095, 4095, 4095);
    idle(LAT);
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b1, 1'b1, i == 16, 4095, 4095, 4095, 4095);
    idle(LAT);

    // One-beat burst
    step(1'b0, 1'b1, 1'b1, 1'b1, -7, 3, 100, -4096);
    idle(LAT);

    // Reset in mid-burst discards it; the beat in the reset cycle is dropped
    step(1'b0, 1'b1, 1'b1, 1'b0, 50, 50, 50, 50);
    step(1'b0, 1'b1, 1'b1, 1'b0, 50, 50, 50, 50);
    step(1'b1, 1'b1, 1'b1, 1'b1, 9, 9, 9, 9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1, 1);
    idle(LAT);

    // Randomised traffic, including invalid beats carrying junk sideband
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           rnd_op(), rnd_op(), rnd_op(), rnd_op());
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
